// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor, LSB-first, DIGIT bits per cycle with a registered carry.
//   Parameters: WIDTH (operand width, >= 2), DIGIT (bits per cycle, must divide WIDTH).
//   Ports:
//     clk, rst_n             clock and asynchronous active-low reset
//     in_valid/in_ready      operand handshake; a, b, mode captured on accept (mode 0 = a+b, 1 = a-b)
//     out_valid/out_ready    result handshake
//     result                 sum or difference (wraps, or saturates when SERIAL_ADD_SUB_SAT_EN is defined)
//     carry_borrow           add: carry out of the MSB; subtract: borrow (a < b unsigned)
//     overflow               two's-complement signed overflow
//   Build option: define SERIAL_ADD_SUB_SAT_EN to saturate result on unsigned out-of-range.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow,
    output logic             overflow
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d, result_q, result_d;
    logic              mode_q, mode_d, carry_q, carry_d, cb_q, cb_d, ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DIGIT:0]    dsum;
    logic              cin_msb, last;

    always_comb begin
        dsum     = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        // carry into the digit's top bit, recovered from its sum bit
        cin_msb  = a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ dsum[DIGIT-1];
        last     = cnt_q == CW'(N - 1);
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cb_d     = cb_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d  = RUN;
                a_sh_d   = a;
                b_sh_d   = b ^ {WIDTH{mode}};
                mode_d   = mode;
                carry_d  = mode;
                cnt_d    = '0;
                res_sh_d = '0;
            end
            RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                carry_d  = dsum[DIGIT];
                res_sh_d = WIDTH'({dsum[DIGIT-1:0], res_sh_q} >> DIGIT);
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    state_d  = DONE;
                    cb_d     = dsum[DIGIT] ^ mode_q;
                    ovf_d    = cin_msb ^ dsum[DIGIT];
`ifdef SERIAL_ADD_SUB_SAT_EN
                    result_d = cb_d ? (mode_q ? '0 : '1) : res_sh_d;
`else
                    result_d = res_sh_d;
`endif
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            mode_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cb_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cb_q     <= cb_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready     = state_q == IDLE;
    assign out_valid    = state_q == DONE;
    assign result       = result_q;
    assign carry_borrow = cb_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed self-checking bench for serial_add_sub (8/1 and 16/4 instances).
module tb_serial_add_sub;
`ifdef SERIAL_ADD_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid8 = 1'b0, out_ready8 = 1'b0, mode8 = 1'b0;
    logic in_valid16 = 1'b0, out_ready16 = 1'b0, mode16 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, res8;
    logic [15:0] a16 = '0, b16 = '0, res16;
    logic in_ready8, out_valid8, cb8, ov8, in_ready16, out_valid16, cb16, ov16;
    logic sel = 1'b0;
    logic [15:0] res_m;
    logic rdy_m, vld_m, cb_m, ov_m;
    int n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8), .result(res8),
        .carry_borrow(cb8), .overflow(ov8));

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
        .mode(mode16), .out_valid(out_valid16), .out_ready(out_ready16), .result(res16),
        .carry_borrow(cb16), .overflow(ov16));

    assign res_m = sel ? res16 : {8'h00, res8};
    assign rdy_m = sel ? in_ready16 : in_ready8;
    assign vld_m = sel ? out_valid16 : out_valid8;
    assign cb_m  = sel ? cb16 : cb8;
    assign ov_m  = sel ? ov16 : ov8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!vld_m && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic op(input bit s, input logic [15:0] aa, input logic [15:0] bb, input logic m,
                      input logic [15:0] er, input logic ecb, input logic eov, input string tag);
        int cyc;
        @(negedge clk);
        sel = s;
        #1;
        check({tag, "_rdy"}, rdy_m, 1);
        if (s) begin a16 = aa; b16 = bb; mode16 = m; in_valid16 = 1'b1; end
        else begin a8 = aa[7:0]; b8 = bb[7:0]; mode8 = m; in_valid8 = 1'b1; end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0; in_valid16 = 1'b0;
        a8 = ~a8; b8 = ~b8; mode8 = ~mode8; a16 = ~a16; b16 = ~b16; mode16 = ~mode16;
        wait_valid(cyc);
        check({tag, "_lat"}, cyc, s ? 4 : 8);
        check({tag, "_res"}, res_m, er);
        check({tag, "_cb"}, cb_m, ecb);
        check({tag, "_ov"}, ov_m, eov);
        @(negedge clk);
        out_ready8 = 1'b1; out_ready16 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0; out_ready16 = 1'b0;
        check({tag, "_vld_clr"}, vld_m, 0);
        check({tag, "_rdy_back"}, rdy_m, 1);
        check({tag, "_res_hold"}, res_m, er);
    endtask

    initial begin
        int cyc, stale;
        #12;
        check("rst_rdy", in_ready8, 1);
        check("rst_vld", out_valid8, 0);
        check("rst_res", res8, 0);
        check("rst_cb", cb8, 0);
        check("rst_ov", ov8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 200, 100, 0, SAT ? 255 : 44, 1, 0, "add_200_100");
        op(0, 100, 50, 0, 150, 0, 1, "add_100_50");
        op(0, 5, 7, 1, SAT ? 0 : 254, 1, 0, "sub_5_7");
        op(0, 'h80, 'h01, 1, 'h7F, 0, 1, "sub_80_01");
        op(0, 'h7F, 'h01, 0, 'h80, 0, 1, "add_7f_01");
        op(0, 'hFF, 'h01, 0, SAT ? 'hFF : 'h00, 1, 0, "add_ff_01");
        op(0, 7, 7, 1, 0, 0, 0, "sub_7_7");
        op(0, 0, 'h80, 1, SAT ? 0 : 'h80, 1, 1, "sub_0_80");
        op(1, 'h1234, 'h0235, 1, 'h0FFF, 0, 0, "w16_sub");
        op(1, 'hFFFF, 'h0001, 0, SAT ? 'hFFFF : 'h0000, 1, 0, "w16_add_wrap");
        op(1, 'h7FFF, 'h0001, 0, 'h8000, 0, 1, "w16_add_ovf");
        // backpressure with in_valid held high through DONE
        sel = 1'b0;
        @(negedge clk);
        a8 = 10; b8 = 20; mode8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        a8 = 3; b8 = 4;
        wait_valid(cyc);
        check("bp_lat", cyc, 8);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_vld", out_valid8, 1);
            check("bp_res", res8, 30);
            check("bp_cb", cb8, 0);
            check("bp_rdy", in_ready8, 0);
        end
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        check("bp_rdy_after", in_ready8, 1);
        check("bp_vld_after", out_valid8, 0);
        @(posedge clk);
        #1;
        check("bp_accept", in_ready8, 0);
        in_valid8 = 1'b0;
        wait_valid(cyc);
        check("bp2_lat", cyc, 8);
        check("bp2_res", res8, 7);
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        // reset in the middle of RUN
        @(negedge clk);
        a8 = 'hF0; b8 = 'h20; mode8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", in_ready8, 1);
        check("mid_rst_vld", out_valid8, 0);
        check("mid_rst_res", res8, 0);
        check("mid_rst_cb", cb8, 0);
        check("mid_rst_ov", ov8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_rdy", in_ready8, 1);
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid8) stale++;
        end
        check("no_stale_vld", stale, 0);
        op(0, 'hF0, 'h20, 0, SAT ? 'hFF : 'h10, 1, 0, "post_rst");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
